// File: rtl/hazard_pkg.sv
// Shared types for the load-use hazard controller: FSM states, output priority
// classes and the decode from a priority class to pipeline control strobes.
package hazard_pkg;

  localparam int REG_X0 = 0;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } haz_state_t;

  typedef enum logic [1:0] {
    PRI_PASS  = 2'd0,
    PRI_STALL = 2'd1,
    PRI_FLUSH = 2'd2,
    PRI_HOLD  = 2'd3
  } haz_pri_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic if_id_flush;
    logic pipe_hold;
  } haz_ctrl_t;

  // Memory wait beats a branch flush, which beats a load-use stall.
  function automatic haz_pri_t haz_priority(input logic hold, input logic flush,
                                            input logic stall);
    haz_pri_t p;
    p = PRI_PASS;
    if (hold)       p = PRI_HOLD;
    else if (flush) p = PRI_FLUSH;
    else if (stall) p = PRI_STALL;
    return p;
  endfunction

  function automatic haz_ctrl_t haz_decode(input haz_pri_t p);
    haz_ctrl_t c;
    c = '0;
    case (p)
      PRI_HOLD: c.pipe_hold = 1'b1;
      PRI_FLUSH: begin
        c.pc_write     = 1'b1;
        c.if_id_write  = 1'b1;
        c.id_ex_bubble = 1'b1;
        c.if_id_flush  = 1'b1;
      end
      PRI_STALL: c.id_ex_bubble = 1'b1;
      default: begin
        c.pc_write    = 1'b1;
        c.if_id_write = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/haz_src_match.sv
// Combinational compare of the ID/EX load destination against every decode
// source, ignoring x0 and sources the instruction does not actually read.
module haz_src_match #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
) (
  input  logic                      mem_read,
  input  logic [REG_AW-1:0]         rd,
  input  logic [NUM_SRC*REG_AW-1:0] rs,
  input  logic [NUM_SRC-1:0]        rs_used,
  output logic                      match
);
  import hazard_pkg::*;

  logic hit;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_used[i] && (rs[i*REG_AW +: REG_AW] == rd)) hit = 1'b1;
    end
    match = mem_read && (rd != REG_AW'(REG_X0)) && hit;
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard controller: stalls IF/ID for LOAD_LAT cycles, freezes on a
// data-memory wait and lets branch flushes squash pending stalls.
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      id_ex_mem_read,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic [NUM_SRC*REG_AW-1:0] if_id_rs,
  input  logic [NUM_SRC-1:0]        if_id_rs_used,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  input  logic                      branch_taken,
  output logic                      pc_write,
  output logic                      if_id_write,
  output logic                      id_ex_bubble,
  output logic                      if_id_flush,
  output logic                      pipe_hold
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               flush_count
`endif
);
  import hazard_pkg::*;

  haz_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             match;
  logic             hold;
  logic             stall_now;
  haz_pri_t         pri;
  haz_ctrl_t        ctrl;

  haz_src_match #(
    .REG_AW (REG_AW),
    .NUM_SRC(NUM_SRC)
  ) u_match (
    .mem_read(id_ex_mem_read),
    .rd      (id_ex_rd),
    .rs      (if_id_rs),
    .rs_used (if_id_rs_used),
    .match   (match)
  );

  // While reset is asserted the strobes show the pass pattern regardless of inputs.
  always_comb begin
    hold      = mem_req && !mem_ready;
    stall_now = ((state == RUN) && match) || (state == LU_STALL);
    pri       = haz_priority(hold, branch_taken, stall_now);
    ctrl      = reset_n ? haz_decode(pri) : haz_decode(PRI_PASS);
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign if_id_flush  = ctrl.if_id_flush;
  assign pipe_hold    = ctrl.pipe_hold;

  // Matches arriving during LU_STALL are ignored: ID/EX already holds a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= '0;
    end else if (pri != PRI_HOLD) begin
      if (pri == PRI_FLUSH) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        case (state)
          RUN: begin
            if (match && (LOAD_LAT > 1)) begin
              state <= LU_STALL;
              cnt   <= CNT_W'(LOAD_LAT - 1);
            end
          end
          LU_STALL: begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((pri == PRI_STALL) && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if ((pri == PRI_FLUSH) && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: two controllers (LOAD_LAT=1 and LOAD_LAT=3) share one
// stimulus stream; a negedge monitor pops hand-computed expectations per cycle.
module tb_hazard_stall_ctrl;

  localparam logic [4:0] PASS  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00100;
  localparam logic [4:0] FLUSH = 5'b11110;
  localparam logic [4:0] HOLD  = 5'b00001;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_ex_mem_read = 1'b0;
  logic [4:0] id_ex_rd = '0;
  logic [9:0] if_id_rs = '0;
  logic [1:0] if_id_rs_used = '0;
  logic       mem_req = 1'b0;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;

  logic pc_w1, ifid_w1, bub1, fl1, hold1;
  logic pc_w3, ifid_w3, bub3, fl3, hold3;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall1, flush1, stall3, flush3;
`endif

  typedef struct {
    string      name;
    logic [4:0] e1;
    logic [4:0] e3;
    bit         chk_perf;
    int         s1;
    int         f1;
    int         s3;
    int         f3;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(3)) dut_l1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rd      (id_ex_rd),
    .if_id_rs      (if_id_rs),
    .if_id_rs_used (if_id_rs_used),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .branch_taken  (branch_taken),
    .pc_write      (pc_w1),
    .if_id_write   (ifid_w1),
    .id_ex_bubble  (bub1),
    .if_id_flush   (fl1),
    .pipe_hold     (hold1)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles  (stall1),
    .flush_count   (flush1)
`endif
  );

  hazard_stall_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(3)) dut_l3 (
    .clk           (clk),
    .reset_n       (reset_n),
    .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rd      (id_ex_rd),
    .if_id_rs      (if_id_rs),
    .if_id_rs_used (if_id_rs_used),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .branch_taken  (branch_taken),
    .pc_write      (pc_w3),
    .if_id_write   (ifid_w3),
    .id_ex_bubble  (bub3),
    .if_id_flush   (fl3),
    .pipe_hold     (hold3)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles  (stall3),
    .flush_count   (flush3)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One call per cycle: drive inputs just after the edge, queue the expectation.
  task automatic applyStimulus(input string name, input logic rst, input logic mr,
                               input logic [4:0] rd, input logic [4:0] rs0,
                               input logic [4:0] rs1, input logic [1:0] used,
                               input logic mreq, input logic mrdy, input logic br,
                               input logic [4:0] e1, input logic [4:0] e3,
                               input bit cp = 1'b0, input int s1 = 0, input int f1 = 0,
                               input int s3 = 0, input int f3 = 0);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n        = !rst;
    id_ex_mem_read = mr;
    id_ex_rd       = rd;
    if_id_rs       = {rs1, rs0};
    if_id_rs_used  = used;
    mem_req        = mreq;
    mem_ready      = mrdy;
    branch_taken   = br;
    e.name = name; e.e1 = e1; e.e3 = e3;
    e.chk_perf = cp; e.s1 = s1; e.f1 = f1; e.s3 = s3; e.f3 = f3;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput({e.name, "/L1"}, {27'd0, pc_w1, ifid_w1, bub1, fl1, hold1}, {27'd0, e.e1});
      checkOutput({e.name, "/L3"}, {27'd0, pc_w3, ifid_w3, bub3, fl3, hold3}, {27'd0, e.e3});
`ifdef HAZ_PERF_CNT_EN
      if (e.chk_perf) begin
        checkOutput({e.name, "/stall_L1"}, stall1, e.s1);
        checkOutput({e.name, "/flush_L1"}, flush1, e.f1);
        checkOutput({e.name, "/stall_L3"}, stall3, e.s3);
        checkOutput({e.name, "/flush_L3"}, flush3, e.f3);
      end
`endif
    end
  end

  initial begin
    //              name               rst mr rd rs0 rs1 used  mrq mrd br  L1     L3
    applyStimulus("reset_idle",        0, 0, 0, 0, 0, 2'b00, 0, 0, 0, PASS,  PASS);
    applyStimulus("t1_load_use",       0, 1, 5, 5, 0, 2'b01, 0, 0, 0, STALL, STALL);
    applyStimulus("t2_stall2",         0, 0, 5, 5, 0, 2'b01, 0, 0, 0, PASS,  STALL);
    applyStimulus("t2_stall3",         0, 0, 5, 5, 0, 2'b01, 0, 0, 0, PASS,  STALL);
    applyStimulus("t2_release",        0, 0, 5, 5, 0, 2'b01, 0, 0, 0, PASS,  PASS);
    applyStimulus("t3_rd_x0",          0, 1, 0, 0, 0, 2'b11, 0, 0, 0, PASS,  PASS,
                  1'b1, 1, 0, 3, 0);
    applyStimulus("t3_rs2_unused",     0, 1, 7, 1, 7, 2'b01, 0, 0, 0, PASS,  PASS);
    applyStimulus("t3_rs2_used",       0, 1, 7, 1, 7, 2'b10, 0, 0, 0, STALL, STALL);
    applyStimulus("t4_branch",         0, 0, 7, 1, 7, 2'b10, 0, 0, 1, FLUSH, FLUSH);
    applyStimulus("t4_after",          0, 0, 7, 1, 7, 2'b10, 0, 0, 0, PASS,  PASS);
    applyStimulus("t5_load_use",       0, 1, 5, 5, 0, 2'b01, 0, 0, 0, STALL, STALL);
    for (int i = 0; i < 4; i++)
      applyStimulus("t5_hold",         0, 0, 5, 5, 0, 2'b01, 1, 0, 0, HOLD,  HOLD);
    applyStimulus("t5_ready",          0, 0, 5, 5, 0, 2'b01, 1, 1, 0, PASS,  STALL);
    applyStimulus("t5_stall_last",     0, 0, 5, 5, 0, 2'b01, 0, 0, 0, PASS,  STALL);
    applyStimulus("t5_release",        0, 0, 5, 5, 0, 2'b01, 0, 0, 0, PASS,  PASS);
    applyStimulus("hold_over_branch",  0, 0, 5, 5, 0, 2'b01, 1, 0, 1, HOLD,  HOLD);
    applyStimulus("idle",              0, 0, 5, 5, 0, 2'b01, 0, 0, 0, PASS,  PASS);
    applyStimulus("t6_load_use",       0, 1, 5, 5, 0, 2'b01, 0, 0, 0, STALL, STALL,
                  1'b1, 3, 1, 7, 1);
    applyStimulus("t6_reset",          1, 0, 5, 5, 0, 2'b01, 0, 0, 0, PASS,  PASS,
                  1'b1, 0, 0, 0, 0);
    applyStimulus("t6_after",          0, 0, 5, 5, 0, 2'b01, 0, 0, 0, PASS,  PASS);
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
